// File: rtl/fixed_alu_driver.sv
// fixed_alu_driver: command-side initiator for the fixed-point ALU
// start/done handshake, with a running Q18.14 accumulator.
module fixed_alu_driver #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_use_acc,
  input  logic        acc_clear,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  input  logic        alu_div_by_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] acc,
  output logic        busy
);

  localparam int CL = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (CL > 5) ? CL : 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          capture;
  logic          expire;

  assign accept  = (state == S_IDLE) && cmd_valid;
  assign capture = (state == S_WAIT) && alu_done;
  // cnt holds the WAIT cycles already spent before this one
  assign expire  = (state == S_WAIT) && !alu_done &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (capture || expire) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == S_ISSUE) begin
      cnt <= '0;
    end else if (state == S_WAIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // operands stay put until the next accept so the
  // combinational div_by_zero is valid on the done cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (accept) begin
      alu_op <= cmd_op;
      alu_a  <= cmd_use_acc ? acc : cmd_a;
      alu_b  <= cmd_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else if (capture) begin
      rsp_result <= alu_result;
      rsp_flags  <= {1'b0, alu_div_by_zero,
                     alu_underflow, alu_overflow};
    end else if (expire) begin
      rsp_result <= '0;
      rsp_flags  <= 4'b1000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (acc_clear) begin
      acc <= '0;
    end else if (capture && !alu_div_by_zero) begin
      acc <= alu_result;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign alu_start = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fixed_alu_driver.sv
// Bench for fixed_alu_driver: behavioural 3-cycle ALU stub,
// table-driven commands plus backpressure, reset and clear cases.
module tb_fixed_alu_driver;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_use_acc;
  logic        acc_clear;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_done;
  logic        alu_overflow;
  logic        alu_underflow;
  logic        alu_div_by_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [31:0] acc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fixed_alu_driver #(.TIMEOUT_CYCLES(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .cmd_use_acc     (cmd_use_acc),
    .acc_clear       (acc_clear),
    .alu_start       (alu_start),
    .alu_op          (alu_op),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_result      (alu_result),
    .alu_done        (alu_done),
    .alu_overflow    (alu_overflow),
    .alu_underflow   (alu_underflow),
    .alu_div_by_zero (alu_div_by_zero),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_flags       (rsp_flags),
    .acc             (acc),
    .busy            (busy)
  );

  // ALU stub: done three cycles after start, unless muted
  logic [2:0]         sr;
  logic               mute;
  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [63:0] wide;

  always @(posedge clk or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= {sr[1:0], alu_start};
  end

  assign alu_done = sr[2] && !mute;

  always_comb begin
    alu_result      = '0;
    alu_overflow    = 1'b0;
    alu_underflow   = 1'b0;
    alu_div_by_zero = 1'b0;
    sa   = {{32{alu_a[31]}}, alu_a};
    sb   = {{32{alu_b[31]}}, alu_b};
    wide = '0;
    case (alu_op)
      OP_ADD: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) &&
                       (alu_result[31] != alu_a[31]);
      end
      OP_SUB: alu_result = alu_a - alu_b;
      OP_MUL: begin
        wide       = (sa * sb) >>> 14;
        alu_result = wide[31:0];
      end
      OP_DIV: begin
        if (alu_b == 32'd0) begin
          alu_div_by_zero = 1'b1;
        end else begin
          wide       = (sa <<< 14) / sb;
          alu_result = wide[31:0];
        end
      end
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_acc;
    logic        mute;
    logic [31:0] res;
    logic [3:0]  flags;
    logic [31:0] acc;
    logic [31:0] ea;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_timeout_bound", 32'(rsp_valid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int t_st;
    int t_rsp;
    string s;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    check({s, "_ready"}, 32'(cmd_ready), 32'd1);
    mute        = v.mute;
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_a       = v.a;
    cmd_b       = v.b;
    cmd_use_acc = v.use_acc;
    rsp_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc   = 1;
    t_st  = -1;
    t_rsp = -1;
    while (t_rsp < 0 && cyc < 40) begin
      if (alu_start && t_st < 0) t_st = cyc;
      if (rsp_valid) begin
        t_rsp = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({s, "_start_cyc"}, 32'(t_st), 32'd1);
    check({s, "_rsp_cyc"}, 32'(t_rsp), 32'(v.lat));
    check({s, "_result"}, rsp_result, v.res);
    check({s, "_flags"}, 32'(rsp_flags), 32'(v.flags));
    check({s, "_acc"}, acc, v.acc);
    check({s, "_alu_a"}, alu_a, v.ea);
    check({s, "_alu_b"}, alu_b, v.b);
    @(negedge clk);
    check({s, "_idle"}, 32'(cmd_ready), 32'd1);
    check({s, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    mute = 1'b0;
  endtask

  initial begin
    int cyc;
    bit saw;

    vecs[0] = '{OP_ADD, 32'h00006000, 32'h00009000, 1'b0, 1'b0,
                32'h0000F000, 4'b0000, 32'h0000F000, 32'h00006000, 5};
    vecs[1] = '{OP_MUL, 32'h0000DEAD, 32'h00008000, 1'b1, 1'b0,
                32'h0001E000, 4'b0000, 32'h0001E000, 32'h0000F000, 5};
    vecs[2] = '{OP_DIV, 32'h00004000, 32'h00000000, 1'b0, 1'b0,
                32'h00000000, 4'b0100, 32'h0001E000, 32'h00004000, 5};
    vecs[3] = '{OP_SUB, 32'h00000000, 32'h00006000, 1'b1, 1'b0,
                32'h00018000, 4'b0000, 32'h00018000, 32'h0001E000, 5};
    vecs[4] = '{OP_DIV, 32'h00000000, 32'h00008000, 1'b1, 1'b0,
                32'h0000C000, 4'b0000, 32'h0000C000, 32'h00018000, 5};
    vecs[5] = '{OP_SUB, 32'h00000000, 32'h00004000, 1'b0, 1'b0,
                32'hFFFFC000, 4'b0000, 32'hFFFFC000, 32'h00000000, 5};
    vecs[6] = '{OP_ADD, 32'h7FFFF000, 32'h00001000, 1'b0, 1'b0,
                32'h80000000, 4'b0001, 32'h80000000, 32'h7FFFF000, 5};
    vecs[7] = '{OP_ADD, 32'h00000001, 32'h00000002, 1'b0, 1'b1,
                32'h00000000, 4'b1000, 32'h80000000, 32'h00000001, 17};
    vecs[8] = '{OP_ADD, 32'h00000000, 32'h00004000, 1'b1, 1'b0,
                32'h80004000, 4'b0000, 32'h80004000, 32'h80000000, 5};

    reset       = 1'b1;
    mute        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_use_acc = 1'b0;
    acc_clear   = 1'b0;
    rsp_ready   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_acc", acc, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // backpressure with a second command waiting
    @(negedge clk);
    rsp_ready   = 1'b0;
    cmd_valid   = 1'b1;
    cmd_op      = OP_ADD;
    cmd_a       = 32'h00004000;
    cmd_b       = 32'h00004000;
    cmd_use_acc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_SUB;
    cmd_a  = 32'h00010000;
    cmd_b  = 32'h00004000;
    wait_rsp(cyc);
    check("bp_result", rsp_result, 32'h00008000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_res", rsp_result, 32'h00008000);
      check("bp_hold_flg", 32'(rsp_flags), 32'd0);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_alu_op", 32'(alu_op), 32'(OP_ADD));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    check("bp_no_start", 32'(alu_start), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp2_start", 32'(alu_start), 32'd1);
    check("bp2_op", 32'(alu_op), 32'(OP_SUB));
    check("bp2_a", alu_a, 32'h00010000);
    wait_rsp(cyc);
    check("bp2_result", rsp_result, 32'h0000C000);
    check("bp2_acc", acc, 32'h0000C000);
    @(negedge clk);

    // reset while waiting on the ALU
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_a     = 32'h00001000;
    cmd_b     = 32'h00001000;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_start", 32'(alu_start), 32'd0);
    check("mid_alu_op", 32'(alu_op), 32'd0);
    check("mid_alu_a", alu_a, 32'd0);
    check("mid_alu_b", alu_b, 32'd0);
    check("mid_acc", acc, 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rsp_result", rsp_result, 32'd0);
    check("mid_rsp_flags", 32'(rsp_flags), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    check("mid_no_rsp", 32'(saw), 32'd0);

    // acc_clear on accept, then on the capture cycle
    vecs[0] = '{OP_ADD, 32'h00002000, 32'h00001000, 1'b0, 1'b0,
                32'h00003000, 4'b0000, 32'h00003000, 32'h00002000, 5};
    run_vec(vecs[0], 9);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = OP_ADD;
    cmd_b       = 32'h00001000;
    cmd_use_acc = 1'b1;
    acc_clear   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_use_acc = 1'b0;
    acc_clear   = 1'b0;
    check("clr_acc_pre_a", alu_a, 32'h00003000);
    check("clr_acc_zero", acc, 32'd0);
    repeat (3) @(negedge clk);
    check("clr_done_cyc", 32'(alu_done), 32'd1);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    check("clr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("clr_rsp_result", rsp_result, 32'h00004000);
    check("clr_cap_acc", acc, 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fixed_alu_driver.md
# fixed_alu_driver

Command-side initiator for the fixed-point ALU's start/done handshake. It accepts calculator commands over a valid/ready interface and drives `operation`, `operand_a`, `operand_b` and a one-cycle `start` pulse into the ALU. It waits for `done`, captures the result and the error flags, and returns them over a valid/ready response interface. It also holds a running accumulator, so chained calculator entries such as "result op B" need no operand round-trip from upstream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 15: the maximum number of WAIT cycles without `alu_done` before the driver aborts the operation.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the driver accepts the command on `cmd_valid && cmd_ready`.
- `cmd_op` in 4: ALU opcode (OP_* encoding from alu_defines).
- `cmd_a` in 32: operand A, Q18.14.
- `cmd_b` in 32: operand B, Q18.14.
- `cmd_use_acc` in 1: when 1, use the accumulator in place of `cmd_a`.
- `acc_clear` in 1: synchronous pulse that sets the accumulator to 0.
- `alu_start` out 1: one-cycle start pulse to the ALU.
- `alu_op` out 4: opcode driven to the ALU.
- `alu_a` out 32: operand A driven to the ALU.
- `alu_b` out 32: operand B driven to the ALU.
- `alu_result` in 32: ALU result.
- `alu_done` in 1: ALU completion pulse.
- `alu_overflow` in 1: ALU overflow flag.
- `alu_underflow` in 1: ALU underflow flag.
- `alu_div_by_zero` in 1: ALU divide-by-zero flag. It is combinational from the operands.
- `rsp_valid` out 1: a response is present.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_result` out 32: captured result.
- `rsp_flags` out 4: {timeout, div_by_zero, underflow, overflow}.
- `acc` out 32: current accumulator value.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_op` and `cmd_b`. Latch A as `cmd_use_acc ? acc : cmd_a`. Go to ISSUE.
  - ISSUE: `alu_start`=1 for exactly one cycle. Go to WAIT. Clear the timeout counter.
  - WAIT: increment the counter each cycle.
    - On `alu_done`: capture `alu_result` into `rsp_result`. Capture {0, `alu_div_by_zero`, `alu_underflow`, `alu_overflow`} into `rsp_flags`. Go to RESP.
    - If the counter reaches `TIMEOUT_CYCLES` without `alu_done`: set `rsp_result`=0 and `rsp_flags`=4'b1000. Go to RESP.
  - RESP: `rsp_valid`=1. `rsp_result` and `rsp_flags` stay stable until `rsp_ready`. On `rsp_ready`, go to IDLE.
- `alu_op`, `alu_a` and `alu_b` come from the latched command registers. They are held stable from ISSUE through the end of RESP. Holding them this long is what makes the combinational `alu_div_by_zero` valid when it is sampled on the done cycle.
- Accumulator update happens on the `alu_done` capture edge:
  - `acc` <= `alu_result` when div_by_zero=0.
  - On divide-by-zero or timeout, `acc` is unchanged.
- `acc_clear`:
  - Applies in any state.
  - If it lands on the same cycle as a capture, the clear wins and `acc` becomes 0.
  - If it lands on the same cycle as IDLE accepting a command with `cmd_use_acc`, the command latches the pre-clear `acc` value.
- `alu_done` seen outside WAIT is ignored.
- `cmd_ready` is 0 in ISSUE, WAIT and RESP. There is no command buffering; exactly one command is in flight.
- Reset mid-operation: every register returns to its reset value and the FSM goes to IDLE. The in-flight command is dropped and no response is produced. The ALU shares the same reset.

## Timing
- Reset values:
  - `cmd_ready`=1 (IDLE).
  - `alu_start`=0.
  - `alu_op`=0, `alu_a`=0, `alu_b`=0.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0.
  - `acc`=0, `busy`=0.
- All outputs are registered or decoded from the state register only. No output depends combinationally on any input.
- Cycle-level sequence with the current ALU (3-cycle start-to-done):
  - Cycle 0: accept.
  - Cycle 1: `alu_start` high.
  - Cycle 4: `alu_done` high.
  - Cycle 5: `rsp_valid` high.
- End-to-end latency from accept to `rsp_valid` is 5 cycles.
- Next-command acceptance:
  - With `rsp_ready` held high, the response completes in cycle 5.
  - IDLE is re-entered at cycle 6.
  - The next accept is at cycle 6, giving a throughput of 1 op per 6 cycles.
- `alu_start` never asserts while `alu_done` is high, and never earlier than 2 cycles after the previous `alu_done`.
- The timeout counter is at least 5 bits wide. A timeout response appears `TIMEOUT_CYCLES`+1 cycles after ISSUE.

## Test plan
- ADD, A=0x00006000 (1.5), B=0x00009000 (2.25), `rsp_ready`=1 -> `alu_start` pulse in cycle 1, `rsp_valid` in cycle 5, `rsp_result`=0x0000F000, `rsp_flags`=0, `acc`=0x0000F000.
- Chaining: after the previous test, MUL with `cmd_use_acc`=1 and B=0x00008000 (2.0) -> `alu_a`=0x0000F000, result 0x0001E000 (7.5), `acc` updated to 0x0001E000.
- DIV with B=0 -> `rsp_flags`=4'b0100, `acc` unchanged. `alu_a` and `alu_b` stay stable through RESP.
- ALU stub that never asserts `alu_done` -> response with `rsp_result`=0 and `rsp_flags`=4'b1000 at ISSUE+16 cycles. The driver then returns to IDLE and the next command completes normally.
- Backpressure: hold `rsp_ready`=0 for 10 cycles -> `rsp_valid`, `rsp_result` and `rsp_flags` stay stable, `cmd_ready` stays 0, and a second command held on `cmd_valid` is not accepted until one cycle after the `rsp_ready` handshake.
- Assert `reset` in WAIT (cycle 3) -> all outputs return to their reset values and no `rsp_valid` occurs. Assert `acc_clear` on the capture cycle -> `acc`=0.
